// File: rtl/raster_address_counter.sv
// Row-major 2D raster walker: presents (x, y, address) under valid/ready and
// pulses done after the last pixel of each pass; address tracks y*WIDTH+x incrementally.
module raster_address_counter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rasterCounterReset,
  input  logic              start,
  input  logic              abort,
  input  logic              loopMode,
  input  logic              ready,
  output logic              valid,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] address,
  output logic              lastPixel,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  state_t              state, state_n;
  logic [X_W-1:0]      x_n;
  logic [Y_W-1:0]      y_n;
  logic [ADDR_W-1:0]   addr_n;
  logic                valid_n, done_n;
  logic                hs, x_end, at_last;

  assign hs        = valid && ready;
  assign x_end     = (x == X_LAST);
  assign at_last   = x_end && (y == Y_LAST);
  assign lastPixel = valid && at_last;

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    addr_n  = address;
    valid_n = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        x_n    = '0;
        y_n    = '0;
        addr_n = '0;
        if (start) begin
          state_n = RUN;
          valid_n = 1'b1;
        end
      end
      RUN: begin
        valid_n = 1'b1;
        if (hs) begin
          if (!x_end) begin
            x_n    = x + X_W'(1);
            addr_n = address + ADDR_W'(1);
          end else if (!at_last) begin
            x_n    = '0;
            y_n    = y + Y_W'(1);
            addr_n = address + ADDR_W'(1);
          end else begin
            // End of region: loop keeps valid up, single pass drops into DONE.
            x_n    = '0;
            y_n    = '0;
            addr_n = '0;
            done_n = 1'b1;
            if (!loopMode) begin
              state_n = DONE;
              valid_n = 1'b0;
            end
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        x_n     = '0;
        y_n     = '0;
        addr_n  = '0;
      end
      default: begin
        state_n = IDLE;
        x_n     = '0;
        y_n     = '0;
        addr_n  = '0;
      end
    endcase
    // Abort outranks everything, including a done pulse on the last pixel.
    if (abort) begin
      state_n = IDLE;
      x_n     = '0;
      y_n     = '0;
      addr_n  = '0;
      valid_n = 1'b0;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rasterCounterReset) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      address <= '0;
      valid   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      x       <= x_n;
      y       <= y_n;
      address <= addr_n;
      valid   <= valid_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_raster_address_counter.sv
// Directed bench for raster_address_counter: three instances (4x3, 1x1, 160x120) share
// the stimulus; a linear-index model is compared every cycle, plus literal spot checks.
module tb_raster_address_counter;

  logic clk = 1'b0;
  logic rst, start, abort, loop_mode, ready;

  logic       v0, l0, d0;  logic [1:0] x0, y0;  logic [3:0]  a0;
  logic       v1, l1, d1;  logic [0:0] x1, y1;  logic [0:0]  a1;
  logic       v2, l2, d2;  logic [7:0] x2;      logic [6:0]  y2;  logic [14:0] a2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  raster_address_counter #(.WIDTH(4), .HEIGHT(3), .X_W(2), .Y_W(2), .ADDR_W(4)) u_small (
    .clk(clk), .rasterCounterReset(rst), .start(start), .abort(abort), .loopMode(loop_mode),
    .ready(ready), .valid(v0), .x(x0), .y(y0), .address(a0), .lastPixel(l0), .done(d0));

  raster_address_counter #(.WIDTH(1), .HEIGHT(1), .X_W(1), .Y_W(1), .ADDR_W(1)) u_one (
    .clk(clk), .rasterCounterReset(rst), .start(start), .abort(abort), .loopMode(loop_mode),
    .ready(ready), .valid(v1), .x(x1), .y(y1), .address(a1), .lastPixel(l1), .done(d1));

  raster_address_counter u_big (
    .clk(clk), .rasterCounterReset(rst), .start(start), .abort(abort), .loopMode(loop_mode),
    .ready(ready), .valid(v2), .x(x2), .y(y2), .address(a2), .lastPixel(l2), .done(d2));

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: pixel index p walks 0..W*H-1; coordinates derive from it by div/mod.
  int mw[3] = '{4, 1, 160};
  int mh[3] = '{3, 1, 120};
  int mst[3];          // 0 idle, 1 scanning, 2 finishing
  int mp[3];
  bit mv[3], md[3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || abort) begin
        mst[i] = 0; mp[i] = 0; mv[i] = 0; md[i] = 0;
      end else if (mst[i] == 0) begin
        md[i] = 0;
        if (start) begin mst[i] = 1; mv[i] = 1; mp[i] = 0; end
      end else if (mst[i] == 1) begin
        md[i] = 0;
        if (ready) begin
          if (mp[i] == mw[i] * mh[i] - 1) begin
            mp[i] = 0; md[i] = 1;
            if (!loop_mode) begin mst[i] = 2; mv[i] = 0; end
          end else mp[i] = mp[i] + 1;
        end
      end else begin
        mst[i] = 0; mv[i] = 0; md[i] = 0; mp[i] = 0;
      end
    end
  end

  task automatic cmp_one(input int i, input string tag, input bit v, input bit d, input bit l,
                         input int x, input int y, input int a);
    chk({tag, ".valid"},   int'(v), int'(mv[i]));
    chk({tag, ".done"},    int'(d), int'(md[i]));
    chk({tag, ".x"},       x, mp[i] % mw[i]);
    chk({tag, ".y"},       y, mp[i] / mw[i]);
    chk({tag, ".address"}, a, mp[i]);
    chk({tag, ".last"},    int'(l), int'(mv[i] && mp[i] == mw[i] * mh[i] - 1));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp_one(0, "m4x3", v0, d0, l0, int'(x0), int'(y0), int'(a0));
      cmp_one(1, "m1x1", v1, d1, l1, int'(x1), int'(y1), int'(a1));
      cmp_one(2, "m160", v2, d2, l2, int'(x2), int'(y2), int'(a2));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  initial begin
    int acc, prev_a, cnt;
    bit prev_r, seen, tmo;
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop_mode = 1'b0; ready = 1'b1;
    cyc(1);
    chk("rst_valid", int'(v0), 0); chk("rst_done", int'(d0), 0);
    chk("rst_addr", int'(a0), 0); chk("rst_xy", int'(x0) + int'(y0), 0);
    cyc(1);
    chk("rst2_valid", int'(v0), 0); chk("rst2_addr", int'(a0), 0);
    rst = 1'b0;
    cyc(2);
    chk("idle_valid", int'(v0), 0);

    // Single pass, ready high.
    pulse_start();
    chk("one_last", int'(l1), 1);
    for (int k = 0; k < 12; k++) begin
      chk("sp_valid", int'(v0), 1);
      chk("sp_addr", int'(a0), k);
      chk("sp_last", int'(l0), int'(k == 11));
      if (k == 1) chk("one_done", int'(d1), 1);
      if (k == 3) begin chk("sp_x3", int'(x0), 3); chk("sp_y3", int'(y0), 0); end
      if (k == 4) begin chk("sp_x4", int'(x0), 0); chk("sp_y4", int'(y0), 1); end
      cyc(1);
    end
    chk("sp_done", int'(d0), 1); chk("sp_done_valid", int'(v0), 0);
    start = 1'b1;  // ignored in DONE, taken in the following IDLE cycle
    cyc(1);
    chk("sp_idle_done", int'(d0), 0); chk("sp_idle_valid", int'(v0), 0);
    cyc(1); start = 1'b0;
    chk("restart_valid", int'(v0), 1); chk("restart_addr", int'(a0), 0);
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("abort_idle", int'(v0), 0);

    // Backpressure: ready 1,0,0,1 repeating.
    ready = 1'b0;
    pulse_start();
    acc = 0; seen = 0;
    for (int c = 0; c < 60; c++) begin
      ready = (c % 4 == 0) || (c % 4 == 3);
      if (v0 && ready) acc++;
      prev_a = int'(a0); prev_r = ready;
      cyc(1);
      if (!prev_r && v0) chk("bp_hold", int'(a0), prev_a);
      if (acc == 12) begin
        chk("bp_done", int'(d0), 1);
        seen = 1;
        break;
      end
    end
    chk("bp_done_seen", int'(seen), 1);
    ready = 1'b1;
    cyc(2);

    // Loop mode, then drop loopMode inside the fourth pass.
    loop_mode = 1'b1;
    pulse_start();
    for (int k = 0; k < 48; k++) begin
      if (k == 40) loop_mode = 1'b0;
      chk("lp_addr", int'(a0), k % 12);
      chk("lp_valid", int'(v0), 1);
      chk("lp_done", int'(d0), int'(k > 0 && k % 12 == 0));
      cyc(1);
    end
    chk("lp_end_done", int'(d0), 1); chk("lp_end_valid", int'(v0), 0);
    cyc(2);

    // Abort rules.
    pulse_start();
    cyc(2);
    start = 1'b1; cyc(1); start = 1'b0;  // mid-pass start ignored
    chk("run_start_ign", int'(a0), 3);
    cyc(3);
    chk("ab_at6", int'(a0), 6);
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("ab_valid", int'(v0), 0); chk("ab_addr", int'(a0), 0);
    cyc(1); chk("ab_nodone", int'(d0), 0);
    abort = 1'b1; start = 1'b1; cyc(1); abort = 1'b0; start = 1'b0;
    chk("ab_start_idle", int'(v0), 0);
    cyc(1); chk("ab_start_idle2", int'(v0), 0);
    pulse_start();
    cyc(11);
    chk("ab_last_addr", int'(a0), 11);
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("ab_last_nodone", int'(d0), 0); chk("ab_last_valid", int'(v0), 0);
    cyc(1); chk("ab_last_nodone2", int'(d0), 0);

    // Full default region.
    pulse_start();
    cnt = 0; tmo = 1;
    for (int c = 0; c < 20000; c++) begin
      if (d2) begin tmo = 0; break; end
      if (v2) cnt++;
      if (int'(a2) == 19199) begin
        chk("big_x", int'(x2), 159); chk("big_y", int'(y2), 119); chk("big_last", int'(l2), 1);
      end
      cyc(1);
    end
    chk("big_timeout", int'(tmo), 0);
    chk("big_cycles", cnt, 19200);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
